// File: rtl/baud_tick_gen_if.sv
// Divisor load bus for the baud tick generator.
// The host drives a one-cycle load strobe with the new divisor.
interface baud_tick_gen_if #(
   parameter int BITS      = 11,
   parameter int FRAC_BITS = 4
);
   logic                 load;
   logic [BITS-1:0]      divisor_int;
   logic [FRAC_BITS-1:0] divisor_frac;

   modport master (output load, divisor_int, divisor_frac);
   modport slave  (input  load, divisor_int, divisor_frac);
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate oversample tick generator.
// Emits one tick per divisor period and a bit tick every OVERSAMPLE ticks.
module baud_tick_gen #(
   parameter int BITS        = 11,
   parameter int FRAC_BITS   = 4,
   parameter int OVERSAMPLE  = 16,
   parameter int DEFAULT_DIV = 650
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          align,
   baud_tick_gen_if.slave                cfg,
   output logic [BITS-1:0]               Q_reg,
   output logic                          tick,
   output logic                          bit_tick,
   output logic [$clog2(OVERSAMPLE)-1:0] os_count
);
   localparam int OSW = $clog2(OVERSAMPLE);

   logic [BITS-1:0]      d_act;
   logic [BITS-1:0]      d_pend;
   logic [FRAC_BITS-1:0] f_act;
   logic [FRAC_BITS-1:0] f_pend;
   logic [FRAC_BITS-1:0] acc;
   logic                 pend;

   logic [BITS-1:0]      d_eff;
   logic [FRAC_BITS:0]   sum;
   logic [BITS:0]        last;
   logic                 term;
   logic                 os_wrap;

   // Period is d_eff plus the fractional carry; last is its terminal count.
   always_comb begin
      d_eff   = (d_act == '0) ? BITS'(1) : d_act;
      sum     = {1'b0, acc} + {1'b0, f_act};
      last    = {1'b0, d_eff} + (BITS+1)'(sum[FRAC_BITS]) - (BITS+1)'(1);
      term    = ({1'b0, Q_reg} == last);
      os_wrap = (os_count == OSW'(OVERSAMPLE - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         Q_reg    <= '0;
         acc      <= '0;
         os_count <= '0;
         tick     <= 1'b0;
         bit_tick <= 1'b0;
         d_act    <= BITS'(DEFAULT_DIV);
         f_act    <= '0;
         d_pend   <= '0;
         f_pend   <= '0;
         pend     <= 1'b0;
      end else if (align) begin
         Q_reg    <= '0;
         acc      <= '0;
         os_count <= OSW'(OVERSAMPLE / 2);
         tick     <= 1'b0;
         bit_tick <= 1'b0;
         pend     <= 1'b0;
         if (cfg.load) begin
            d_act <= cfg.divisor_int;
            f_act <= cfg.divisor_frac;
         end else if (pend) begin
            d_act <= d_pend;
            f_act <= f_pend;
         end
      end else begin
         tick     <= enable & term;
         bit_tick <= enable & term & os_wrap;
         if (enable) begin
            if (term) begin
               Q_reg    <= '0;
               acc      <= sum[FRAC_BITS-1:0];
               os_count <= os_count + OSW'(1);
            end else begin
               Q_reg <= Q_reg + BITS'(1);
            end
         end
         // A load landing on the terminal count takes effect immediately.
         if (cfg.load && enable && term) begin
            d_act <= cfg.divisor_int;
            f_act <= cfg.divisor_frac;
            pend  <= 1'b0;
         end else begin
            if (pend && (!enable || term)) begin
               d_act <= d_pend;
               f_act <= f_pend;
               pend  <= 1'b0;
            end
            if (cfg.load) begin
               d_pend <= cfg.divisor_int;
               f_pend <= cfg.divisor_frac;
               pend   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter BITS, default 11, the integer divisor and counter width.
REQ-002 SHALL have parameter FRAC_BITS, default 4, the fractional divisor width in 1/2^FRAC_BITS units.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit (power of two, >=4).
REQ-004 SHALL have parameter DEFAULT_DIV, default 650, the integer divisor active after reset.
REQ-005 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  run the counter when high, hold all state when low.
REQ-008 SHALL have port load  input  1  one-cycle strobe that captures divisor_int/divisor_frac into shadow registers.
REQ-009 SHALL have port divisor_int  input  BITS  integer part of the divisor.
REQ-010 SHALL have port divisor_frac  input  FRAC_BITS  fractional part of the divisor.
REQ-011 SHALL have port align  input  1  restart strobe used by the RX start-bit detector.
REQ-012 SHALL have port Q_reg  output  BITS  current counter value.
REQ-013 SHALL have port tick  output  1  registered one-cycle oversample tick.
REQ-014 SHALL have port bit_tick  output  1  registered one-cycle tick, once every OVERSAMPLE ticks.
REQ-015 SHALL have port os_count  output  log2(OVERSAMPLE)  current tick index within the bit.

Function
REQ-016 SHALL hold an active divisor (D, F) and a FRAC_BITS accumulator acc; the effective D is max(D,1).
REQ-017 SHALL use period P = D + c, where c is the carry out of (acc + F) on FRAC_BITS+1 bits.
REQ-018 SHALL increment Q_reg each enabled cycle; when Q_reg == P-1 (terminal count), Q_reg <= 0, acc <= (acc+F) mod 2^FRAC_BITS, and tick is registered high for the next cycle.
REQ-019 SHALL, on each terminal count, increment os_count, wrapping OVERSAMPLE-1 -> 0; the wrap registers bit_tick high in the same cycle as tick.
REQ-020 SHALL, with enable low, hold Q_reg, acc and os_count, and drive tick = bit_tick = 0.
REQ-021 SHALL mark a load pending; the pending value becomes active at the next terminal count, or on the next cycle if enable is low.
REQ-022 SHALL, when load and terminal count coincide, use the newly loaded value for the following period.
REQ-023 SHALL, when a second load arrives before the first is applied, keep only the latest value.
REQ-024 SHALL, on align (regardless of enable), set Q_reg <= 0, acc <= 0, os_count <= OVERSAMPLE/2, apply any pending load immediately, and suppress tick/bit_tick that cycle.
REQ-025 SHALL, when align and load coincide, activate the value presented with load.
REQ-026 SHALL give align priority over terminal count, and reset priority over all other inputs.
REQ-027 SHALL, when D <= 1 (effective 1) and F = 0, assert tick every enabled cycle with Q_reg held at 0.

Reset
REQ-028 SHALL, on reset, set Q_reg=0, acc=0, os_count=0, tick=0, bit_tick=0, D=DEFAULT_DIV, F=0 and clear the pending load.
REQ-029 SHALL, on reset asserted mid-period, apply REQ-028 at the next edge and restart counting from 0 once reset is released.

Verification
REQ-030 SHALL check: load D=4,F=0 with enable low, then enable high -> tick every 4 cycles, bit_tick every 64 cycles, coincident with every 16th tick.
REQ-031 SHALL check: D=4, F=8 -> tick intervals alternate 4,5,4,5, averaging 4.5 over 32 ticks.
REQ-032 SHALL check: with D=10 running, load D=3 at Q_reg=5 -> the current period completes at 10, then intervals are 3.
REQ-033 SHALL check: align at Q_reg=2 with D=4 -> no tick that cycle, os_count=8, first bit_tick exactly 8 ticks (32 cycles) later.
REQ-034 SHALL check: enable low for 7 cycles at Q_reg=2 -> Q_reg stays at 2, no ticks, and counting resumes from 3.
REQ-035 SHALL check: reset mid-period -> all outputs at reset values, and D=650 gives the first tick 650 cycles after enable.
